// File: rtl/data_mem_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder_pkg
// Description : Shared constants, request record and access-size helpers for
//               the data-memory responder (funct3 codes, FSM encoding).
//               Optional feature macro used by the design: MISALIGN_TRAP_EN.
// Revision    : 1.0 - initial release
// ============================================================================
package data_mem_responder_pkg;

    // RV32I load/store funct3 codes
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // FSM state encoding
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Access size encoding
    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    // Request fields captured at accept (address is held separately because
    // its width depends on the RAM size)
    typedef struct packed {
        logic        is_write;
        logic [2:0]  funct3;
        logic [31:0] wdata;
    } req_t;

    // Access size from direction and funct3. Stores only know SB/SH; every
    // other store code is a word. Loads use funct3[1:0] so that the unsigned
    // variants share the size of their signed counterparts and 011/11x are words.
    function automatic logic [1:0] access_size(input logic is_write, input logic [2:0] f3);
        logic [1:0] sz;
        if (is_write) begin
            if (f3 == F3_SB)      sz = SZ_BYTE;
            else if (f3 == F3_SH) sz = SZ_HALF;
            else                  sz = SZ_WORD;
        end else begin
            if (f3[1:0] == 2'b00)      sz = SZ_BYTE;
            else if (f3[1:0] == 2'b01) sz = SZ_HALF;
            else                       sz = SZ_WORD;
        end
        return sz;
    endfunction

    // True when the byte offset does not suit the access size
    function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] off);
        logic mis;
        if (sz == SZ_HALF)      mis = off[0];
        else if (sz == SZ_WORD) mis = |off;
        else                    mis = 1'b0;
        return mis;
    endfunction

    // Clears the offset bits an access of this size may not use
    function automatic logic [1:0] align_offset(input logic [1:0] sz, input logic [1:0] off);
        logic [1:0] o;
        if (sz == SZ_HALF)      o = {off[1], 1'b0};
        else if (sz == SZ_WORD) o = 2'b00;
        else                    o = off;
        return o;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_mem_responder_load_extend.sv
`default_nettype none
// ============================================================================
// Module      : load_extend
// Description : Combinational load lane select plus sign/zero extension of a
//               RAM word, driven by the byte offset and load funct3.
// Revision    : 1.0 - initial release
// ============================================================================
module load_extend
    import data_mem_responder_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_offset,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte and halfword lanes
    always_comb begin
        w_byte = i_word[7:0];
        case (i_offset)
            2'd0:    w_byte = i_word[7:0];
            2'd1:    w_byte = i_word[15:8];
            2'd2:    w_byte = i_word[23:16];
            default: w_byte = i_word[31:24];
        endcase
        w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    end

    // Extend the selected lane; unlisted codes return the full word
    always_comb begin
        o_data = i_word;
        case (i_funct3)
            F3_LB:   o_data = {{24{w_byte[7]}}, w_byte};
            F3_LH:   o_data = {{16{w_half[15]}}, w_half};
            F3_LBU:  o_data = {24'h000000, w_byte};
            F3_LHU:  o_data = {16'h0000, w_half};
            default: o_data = i_word;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
// Module      : data_mem_responder
// Description : Data-memory responder. Accepts LeMem/EscreveMem strobes,
//               waits WAIT_CYCLES, then performs a sized load or byte-enabled
//               store on an internal word-organised RAM and pulses ready.
//               Optional macro MISALIGN_TRAP_EN: flag misaligned accesses and
//               suppress them instead of forcing the address into alignment.
// Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder
    import data_mem_responder_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int ADDR_W      = 12
)
(
    input  logic        clock,
    input  logic        reset_n,
    input  logic        LeMem,
    input  logic        EscreveMem,
    input  logic [2:0]  funct3,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic        busy,
    output logic        misaligned
);

    localparam int c_CNT_W = (WAIT_CYCLES < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
    localparam int c_DEPTH = 2 ** (ADDR_W - 2);
    localparam logic [c_CNT_W-1:0] c_WAIT_LOAD = c_CNT_W'(WAIT_CYCLES);
    localparam logic [c_CNT_W-1:0] c_ONE       = c_CNT_W'(1);

    logic [1:0]         r_state;
    logic [1:0]         w_next_state;
    logic [c_CNT_W-1:0] r_count;
    logic [c_CNT_W-1:0] w_next_count;
    logic               w_access;

    req_t               r_req;
    req_t               w_live_req;
    req_t               w_cur_req;
    logic [ADDR_W-1:0]  r_addr;
    logic [ADDR_W-1:0]  w_cur_addr;

    logic               w_strobe;
    logic [1:0]         w_size;
    logic [1:0]         w_offset;
    logic [ADDR_W-3:0]  w_index;
    logic               w_trap;
    logic [3:0]         w_be;
    logic [31:0]        w_store_data;
    logic               w_mem_we;
    logic [31:0]        w_mem_word;
    logic [31:0]        w_load_data;
    logic [31:0]        r_read_data;

    logic [31:0]        r_mem [c_DEPTH];

    // Address bits above the RAM size are ignored, so accesses wrap
    generate
        if (ADDR_W < 32) begin : g_addr_hi
            logic w_unused_addr_hi;
            assign w_unused_addr_hi = ^address[31:ADDR_W];
        end
    endgenerate

    assign w_strobe = LeMem | EscreveMem;

    // A simultaneous read and write is treated as a write
    assign w_live_req = '{is_write: EscreveMem, funct3: funct3, wdata: write_data};

    // With zero wait states the access commits on the accept edge, so the
    // live inputs are used while idle and the captured request afterwards
    assign w_cur_req  = (r_state == S_IDLE) ? w_live_req : r_req;
    assign w_cur_addr = (r_state == S_IDLE) ? address[ADDR_W-1:0] : r_addr;

    assign w_size  = access_size(w_cur_req.is_write, w_cur_req.funct3);
    assign w_index = w_cur_addr[ADDR_W-1:2];

`ifdef MISALIGN_TRAP_EN
    logic r_mis;
    assign w_trap   = is_misaligned(w_size, w_cur_addr[1:0]);
    assign w_offset = w_cur_addr[1:0];
`else
    assign w_trap   = 1'b0;
    assign w_offset = align_offset(w_size, w_cur_addr[1:0]);
`endif

    // Next state, wait counter and access strobe
    always_comb begin
        w_next_state = r_state;
        w_next_count = r_count;
        w_access     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_strobe) begin
                    if (WAIT_CYCLES == 0) begin
                        w_access     = 1'b1;
                        w_next_state = S_DONE;
                    end else begin
                        w_next_count = c_WAIT_LOAD;
                        w_next_state = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                w_next_count = r_count - c_ONE;
                if (r_count <= c_ONE) begin
                    w_next_count = '0;
                    w_access     = 1'b1;
                    w_next_state = S_DONE;
                end
            end
            S_DONE: begin
                w_next_state = S_IDLE;
            end
            default: begin
                w_next_state = S_IDLE;
                w_next_count = '0;
            end
        endcase
    end

    // Byte enables and lane-replicated store data
    always_comb begin
        w_be         = 4'b1111;
        w_store_data = w_cur_req.wdata;
        case (w_size)
            SZ_BYTE: begin
                w_be         = 4'b0001 << w_offset;
                w_store_data = {4{w_cur_req.wdata[7:0]}};
            end
            SZ_HALF: begin
                w_be         = w_offset[1] ? 4'b1100 : 4'b0011;
                w_store_data = {2{w_cur_req.wdata[15:0]}};
            end
            default: begin
                w_be         = 4'b1111;
                w_store_data = w_cur_req.wdata;
            end
        endcase
    end

    assign w_mem_we   = w_access & w_cur_req.is_write & ~w_trap;
    assign w_mem_word = r_mem[w_index];

    load_extend u_load_extend (
        .i_word   (w_mem_word),
        .i_offset (w_offset),
        .i_funct3 (w_cur_req.funct3),
        .o_data   (w_load_data)
    );

    // RAM write port; contents deliberately survive reset
    always_ff @(posedge clock) begin
        for (int b = 0; b < 4; b++) begin
            if (w_mem_we && w_be[b]) begin
                r_mem[w_index][8*b +: 8] <= w_store_data[8*b +: 8];
            end
        end
    end

    // FSM state, counter, request capture and load result
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_IDLE;
            r_count     <= '0;
            r_req       <= '0;
            r_addr      <= '0;
            r_read_data <= '0;
        end else begin
            r_state <= w_next_state;
            r_count <= w_next_count;
            if ((r_state == S_IDLE) && w_strobe) begin
                r_req  <= w_live_req;
                r_addr <= address[ADDR_W-1:0];
            end
            if (w_access && !w_cur_req.is_write) begin
                r_read_data <= w_trap ? 32'h0 : w_load_data;
            end
        end
    end

`ifdef MISALIGN_TRAP_EN
    // Misalignment flag captured with the access, presented with ready
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_mis <= 1'b0;
        end else if (w_access) begin
            r_mis <= w_trap;
        end
    end
    assign misaligned = r_mis & (r_state == S_DONE);
`else
    assign misaligned = 1'b0;
`endif

    assign read_data = r_read_data;
    assign ready     = (r_state == S_DONE);
    assign busy      = ((r_state == S_IDLE) && w_strobe) || (r_state == S_WAIT);

endmodule
`default_nettype wire
